mips_prog_loader: RTL

- Boot-time program loader that sits directly upstream of the pipelined MIPS32 core.
- Receives a byte stream over a valid/ready handshake and assembles it into 32-bit instruction words.
- Writes those words into the core's 1024 x 32 instruction/data memory through a single write port.
- Checks the image against a trailing checksum, then releases the core by asserting core_run.

---
 rtl/mips_prog_loader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mips_prog_loader.sv
// Boot-time loader: assembles a big-endian byte stream into 32-bit words, writes the
// instruction image into the core memory, verifies a trailing checksum, then releases the core.
module mips_prog_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned BASE   = 0
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_run,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded,
    input  logic              restart
);

    typedef enum logic [2:0] {
        ST_HDR,
        ST_LOAD,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [31:0]       MAX_N  = 32'(DEPTH - BASE);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

    state_e              state_q, state_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [23:0]         shift_q, shift_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [31:0]         sum_q, sum_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]     wl_q, wl_d;

    logic                accept;
    logic                word_done;
    logic [31:0]         word;

    // Ready is forced low while reset is held so no byte can slip in during reset.
    assign s_ready   = rst_n & ((state_q == ST_HDR) | (state_q == ST_LOAD) | (state_q == ST_CSUM));
    assign accept    = s_valid & s_ready;
    assign word_done = accept & (bcnt_q == 2'd3);
    assign word      = {shift_q, s_data};

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign core_run     = (state_q == ST_DONE);
    assign load_err     = (state_q == ST_ERR);
    assign words_loaded = wl_q;

    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        n_d         = n_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wl_d        = wl_q;

        if (accept) begin
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q != 2'd3) begin
                shift_d = {shift_q[15:0], s_data};
            end
        end

        if (word_done) begin
            case (state_q)
                ST_HDR: begin
                    idx_d = '0;
                    if (word == 32'd0) begin
                        state_d = ST_CSUM;
                    end else if (word > MAX_N) begin
                        state_d = ST_ERR;
                    end else begin
                        n_d     = word[ADDR_W:0];
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = BASE_A + idx_q[ADDR_W-1:0];
                    mem_wdata_d = word;
                    sum_d       = sum_q + word;
                    wl_d        = idx_q + 1'b1;
                    idx_d       = idx_q + 1'b1;
                    if (idx_q == n_q - 1'b1) begin
                        state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    state_d = (word == sum_q) ? ST_DONE : ST_ERR;
                end
                default: ;
            endcase
        end

        if (restart && ((state_q == ST_DONE) || (state_q == ST_ERR))) begin
            state_d = ST_HDR;
            wl_d    = '0;
            sum_d   = '0;
            idx_d   = '0;
            bcnt_d  = '0;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HDR;
            bcnt_q      <= '0;
            shift_q     <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wl_q        <= '0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wl_q        <= wl_d;
        end
    end

endmodule
